// File: rtl/online_pkg.sv
// Shared definitions for the online arithmetic datapath: signed-digit encodings and
// the on-the-fly converter state type.
package online_pkg;

  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;

  typedef enum logic {
    StIdle,
    StAccum
  } conv_state_e;

endpackage

// File: rtl/otf_step.sv
// One on-the-fly conversion step: appends a signed digit to the (Q, QM = Q-1) pair.
module otf_step
  import online_pkg::*;
#(
  parameter int unsigned W = 17
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic [1:0]   digit,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  // Shifts drop the top bit, giving modulo 2^W arithmetic; 2'b11 falls to the zero case.
  always_comb begin
    q_next  = {q[W-2:0], 1'b0};
    qm_next = {qm[W-2:0], 1'b1};
    case (digit)
      SD_POS: begin
        q_next  = {q[W-2:0], 1'b1};
        qm_next = {q[W-2:0], 1'b0};
      end
      SD_NEG: begin
        q_next  = {qm[W-2:0], 1'b1};
        qm_next = {qm[W-2:0], 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/online_otf_converter.sv
// Serial MSD-first signed-digit stream to two's-complement word converter, no carry
// propagation; one digit per cycle, frames of N digits.
module online_otf_converter
  import online_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] digit_in,
  input  logic       digit_valid,
  input  logic       start,
  output logic [N:0] result,
  output logic       result_valid,
  output logic       busy,
  output logic       frame_err
);

  localparam int unsigned W    = N + 1;
  localparam int unsigned CntW = $clog2(N + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(N);

  conv_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  q_q, q_d, qm_q, qm_d;
  logic [W-1:0]  result_q, result_d;
  logic          rv_q, rv_d, fe_q, fe_d;
  logic [W-1:0]  step_q, step_qm, q_next, qm_next;
  logic          init, accept;

  assign init   = digit_valid & start;
  assign accept = init | (digit_valid & (state_q == StAccum));

  // A start digit restarts from the empty pair Q=0, QM=-1.
  assign step_q  = init ? '0 : q_q;
  assign step_qm = init ? '1 : qm_q;

  otf_step #(
    .W(W)
  ) u_step (
    .q      (step_q),
    .qm     (step_qm),
    .digit  (digit_in),
    .q_next (q_next),
    .qm_next(qm_next)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    qm_d     = qm_q;
    result_d = result_q;
    rv_d     = 1'b0;
    fe_d     = 1'b0;

    if (accept) begin
      q_d     = q_next;
      qm_d    = qm_next;
      state_d = StAccum;
      if (init) begin
        fe_d  = (state_q == StAccum);
        cnt_d = CntW'(1);
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
      if (cnt_d == LastCnt) begin
        result_d = q_next;
        rv_d     = 1'b1;
        state_d  = StIdle;
        cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      q_q      <= '0;
      qm_q     <= '1;
      result_q <= '0;
      rv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      qm_q     <= qm_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      fe_q     <= fe_d;
    end
  end

  assign result       = result_q;
  assign result_valid = rv_q;
  assign frame_err    = fe_q;
  assign busy         = (state_q == StAccum);

endmodule

// File: tb/tb_online_otf_converter.sv
// Scoreboard bench for online_otf_converter (N=4): integer reference model, directed
// test-plan frames followed by randomized digit streams with gaps, aborts and resets.
module tb_online_otf_converter;

  localparam int unsigned N = 4;

  logic       clk;
  logic       rst;
  logic [1:0] digit_in;
  logic       digit_valid;
  logic       start;
  logic [N:0] result;
  logic       result_valid;
  logic       busy;
  logic       frame_err;

  online_otf_converter #(
    .N(N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .start       (start),
    .result      (result),
    .result_valid(result_valid),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit busy;
    bit valid;
    bit err;
    int held;
  } exp_t;

  exp_t cyc_q[$];
  int   res_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: value so far as a plain integer, digits seen in the frame.
  bit m_in_frame = 0;
  int m_acc      = 0;
  int m_cnt      = 0;
  int m_held     = 0;

  function automatic int dval(input logic [1:0] d);
    if (d == 2'b10) return 1;
    if (d == 2'b01) return -1;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Drives one cycle's inputs and predicts the outputs visible after the next edge.
  task automatic drive(input logic r, input logic v, input logic s, input logic [1:0] d);
    exp_t e;
    bit   acc_now;
    @(negedge clk);
    #2;
    rst = r; digit_valid = v; start = s; digit_in = d;
    e.valid = 0;
    e.err   = 0;
    if (r) begin
      m_in_frame = 0;
      m_held     = 0;
      m_cnt      = 0;
    end else begin
      acc_now = 0;
      if (v && s) begin
        e.err      = m_in_frame;
        m_acc      = dval(d);
        m_cnt      = 1;
        m_in_frame = 1;
        acc_now    = 1;
      end else if (v && m_in_frame) begin
        m_acc   = 2 * m_acc + dval(d);
        m_cnt++;
        acc_now = 1;
      end
      if (acc_now && m_cnt == N) begin
        m_held     = m_acc;
        e.valid    = 1;
        m_in_frame = 0;
        res_q.push_back(m_acc);
      end
    end
    e.busy = m_in_frame;
    e.held = m_held;
    cyc_q.push_back(e);
  endtask

  task automatic frame(input logic [1:0] d0, input logic [1:0] d1, input logic [1:0] d2,
                       input logic [1:0] d3);
    drive(0, 1, 1, d0);
    drive(0, 1, 0, d1);
    drive(0, 1, 0, d2);
    drive(0, 1, 0, d3);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 2'b00);
  endtask

  // Monitor: outputs sampled on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    int   r;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      chk("busy", int'(busy), int'(e.busy));
      chk("result_valid", int'(result_valid), int'(e.valid));
      chk("frame_err", int'(frame_err), int'(e.err));
      chk("result_held", int'($signed(result)), e.held);
      if (result_valid && frame_err) chk("valid_err_exclusive", 1, 0);
      if (result_valid) begin
        if (res_q.size() == 0) begin
          chk("unexpected_result", int'($signed(result)), -999);
        end else begin
          r = res_q.pop_front();
          chk("result", int'($signed(result)), r);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; digit_valid = 1'b0; start = 1'b0; digit_in = 2'b00;
    drive(1, 0, 0, 2'b00);
    drive(1, 1, 1, 2'b10);
    idle(2);

    // +1,0,-1,+1 -> 7
    frame(2'b10, 2'b00, 2'b01, 2'b10);
    idle(1);
    // -1,-1,-1,-1 -> -15 ; -1,+1,+1,+1 -> -1
    frame(2'b01, 2'b01, 2'b01, 2'b01);
    frame(2'b01, 2'b10, 2'b10, 2'b10);
    idle(1);
    // Stray digit while idle is ignored
    drive(0, 1, 0, 2'b10);
    // +1,+1,(gap 3),0,0 -> 12
    drive(0, 1, 1, 2'b10);
    drive(0, 1, 0, 2'b10);
    idle(3);
    drive(0, 1, 0, 2'b00);
    drive(0, 1, 0, 2'b00);
    idle(1);
    // Abort after two digits, then 0,0,0,+1 -> 1, back-to-back +1x4 -> 15
    drive(0, 1, 1, 2'b10);
    drive(0, 1, 0, 2'b01);
    frame(2'b00, 2'b00, 2'b00, 2'b10);
    frame(2'b10, 2'b10, 2'b10, 2'b10);
    // Reset after the third digit
    drive(0, 1, 1, 2'b10);
    drive(0, 1, 0, 2'b10);
    drive(0, 1, 0, 2'b10);
    drive(1, 1, 0, 2'b10);
    idle(1);
    // 2'b11 behaves as zero -> 1
    frame(2'b11, 2'b11, 2'b11, 2'b10);
    idle(1);

    // Randomized streams: gaps, aborts, stray digits, rare resets.
    for (int i = 0; i < 600; i++) begin
      logic [1:0] d;
      d = 2'($urandom_range(0, 3));
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 5) == 0), d);
    end

    idle(3);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", res_q.size(), 0);
    chk("cycles_drained", cyc_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/online_otf_converter.md
# online_otf_converter

Serial-to-parallel on-the-fly converter for the online arithmetic datapath. It receives the redundant radix-2 signed-digit stream produced by the online adder, most significant digit first, one digit per clock. It assembles the stream into a conventional two's-complement word without a final carry-propagate addition, so the adder's serial output can be consumed by ordinary binary logic and compared against golden files.

## Interface
- N, 16: digits per frame; the result is N+1 bits signed.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- digit_in  in  2  signed digit {plus, minus}:
  - 2'b10 = +1
  - 2'b01 = −1
  - 2'b00 or 2'b11 = 0
- digit_valid  in  1  digit_in is accepted on this edge. There is no backpressure; the block is always ready.
- start  in  1  marks the first digit of a frame. It is only qualified when digit_valid=1.
- result  out  N+1  converted value, Σ d_i·2^(N−i) for i=1..N. It is held until the next frame completes.
- result_valid  out  1  one-cycle pulse when result updates.
- busy  out  1  a frame is in progress.
- frame_err  out  1  one-cycle pulse when a frame is aborted by a new start.

## Operation
- States:
  - IDLE: busy=0.
  - ACCUM: busy=1. A digit counter cnt runs 1..N.
- Registers Q and QM are N+1 bits each. Invariant: QM = Q − 1.
- Frame init (start & digit_valid): treat the pre-frame values as Q=0 and QM=all-ones (−1), then apply the digit below.
- Update on each accepted digit d, with Q and QM read before the update:
  - d=+1: Q←2Q+1, QM←2Q.
  - d=0: Q←2Q, QM←2QM+1.
  - d=−1: Q←2QM+1, QM←2QM.
- All arithmetic is modulo 2^(N+1); there is no overflow check, since |value| ≤ 2^N−1 always fits.
- Transitions:
  - IDLE → ACCUM on start & digit_valid; cnt←1.
  - ACCUM, digit_valid & !start: cnt←cnt+1. When the accepted digit is the Nth: result←updated Q, result_valid←1, next state IDLE.
  - ACCUM, digit_valid & start: abort the current frame, frame_err←1, re-init from this digit as its first digit (cnt←1). The partial result is discarded and result is unchanged.
  - digit_valid=0: hold all state, including mid-frame gaps of any length.
  - IDLE, digit_valid & !start: digit ignored, no flags.
- N=1 is legal: the frame completes on the start digit itself.

## Timing
- Reset values:
  - state=IDLE, cnt=0, Q=0, QM=all-ones.
  - result=0, result_valid=0, busy=0, frame_err=0.
- Latency: the Nth digit is accepted at edge k; result and result_valid are visible after edge k (one register stage). With no gaps, an N-digit frame starting at edge s completes at edge s+N−1.
- busy rises after the edge accepting the start digit. It falls after the edge accepting the Nth digit, the same edge result_valid rises.
- Back-to-back: start may arrive on the edge immediately after the Nth digit. No idle cycle is required, and full throughput is one digit per cycle.
- rst mid-frame wins over all inputs. The frame is dropped and no result_valid is produced.
- frame_err and result_valid are never high in the same cycle.

## Structure
- Shared package online_pkg holds:
  - the digit encodings SD_POS=2'b10, SD_NEG=2'b01, SD_ZERO=2'b00;
  - the converter state enum {IDLE, ACCUM}.
- online_pkg is also used by the online adder and its digit-stream generators.
- One combinational sub-module, otf_step: it takes (q, qm, digit) and returns (q_next, qm_next) for width N+1. It is reused by the frame-init path with q=0, qm=−1.
- The top level holds the FSM, the counter and the registers; no other hierarchy.

## Test plan
- N=4, digits +1,0,−1,+1 contiguous with start on the first: result=5'b00111 (7), result_valid one cycle after the 4th digit.
- N=4, digits −1,−1,−1,−1: result=5'b10001 (−15). Digits −1,+1,+1,+1: result=5'b11111 (−1), which exercises the QM path.
- N=4, digits +1,+1,0,0 with digit_valid low for 3 cycles after the 2nd digit: result=5'b01100 (12), result_valid 3 cycles later than the contiguous case, busy held through the gap.
- N=4, start after 2 digits, then full frame 0,0,0,+1: one frame_err pulse, then result=5'b00001. An immediately following back-to-back frame +1,+1,+1,+1 gives 5'b01111.
- rst asserted after the 3rd digit: all outputs equal their reset values the next cycle, no result_valid. Digit encoding 2'b11 in a frame behaves exactly as 0 (11,11,11,10 → 5'b00001).
